// File: rtl/mitchell_dot_acc_pkg.sv
// Shared types, default widths and saturation limits for the Mitchell dot-product accumulator.
package mitchell_pkg;

  localparam int unsigned PROD_W_DEF = 17;
  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Largest / smallest two's-complement value of width w (w <= 64).
  function automatic logic signed [63:0] SAT_MAX(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] SAT_MIN(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mitchell_dot_acc_if.sv
// Product-in / result-out handshake bundle for mitchell_dot_acc.
interface mitchell_dot_acc_if
  import mitchell_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res;
  logic              res_ovf;
  logic              busy;

  modport master (
    output start, len, prod_valid, prod, res_ready,
    input  prod_ready, res_valid, res, res_ovf, busy
  );

  modport slave (
    input  start, len, prod_valid, prod, res_ready,
    output prod_ready, res_valid, res, res_ovf, busy
  );
endinterface

// File: rtl/mitchell_dot_acc_sat_add.sv
// Combinational signed saturating adder: ACC_W accumulator plus PROD_W product.
module sat_add
  import mitchell_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned PROD_W = PROD_W_DEF
) (
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(SAT_MAX(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(SAT_MIN(ACC_W));

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {a[ACC_W-1], a} + {{(ACC_W + 1 - PROD_W){b[PROD_W-1]}}, b};
    // One guard bit: overflow iff the two top bits disagree; the guard bit is the true sign.
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    if (!ovf)
      sum = wide[ACC_W-1:0];
    else if (wide[ACC_W])
      sum = MIN_V;
    else
      sum = MAX_V;
  end
endmodule

// File: rtl/mitchell_dot_acc.sv
// Accumulates a programmed number of signed approximate products into one saturated result.
module mitchell_dot_acc
  import mitchell_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mitchell_dot_acc_if.slave  bus
);
  state_e                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [LEN_W-1:0]         cnt;
  logic                     ovf;
  logic                     add_ovf;
  logic                     beat;

  assign beat = bus.prod_valid && (state == ACC);

  sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .a   (acc),
    .b   (bus.prod),
    .sum (acc_next),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= bus.len;
            state <= (bus.len == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (beat) begin
            acc <= acc_next;
            ovf <= ovf | add_ovf;
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1))
              state <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free and zero after reset.
  assign bus.prod_ready = (state == ACC);
  assign bus.res_valid  = (state == DONE);
  assign bus.res        = (state == DONE) ? acc : '0;
  assign bus.res_ovf    = (state == DONE) & ovf;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mitchell_dot_acc.sv
// Self-checking bench: vector table, corner-case sequences and randomized runs against a saturating-sum model.
module tb_mitchell_dot_acc;
  import mitchell_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mitchell_dot_acc_if #(.PROD_W(17), .ACC_W(32), .LEN_W(8)) bus ();
  mitchell_dot_acc_if #(.PROD_W(17), .ACC_W(20), .LEN_W(8)) bus20 ();

  mitchell_dot_acc #(.PROD_W(17), .ACC_W(32), .LEN_W(8)) dut (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus)
  );
  mitchell_dot_acc #(.PROD_W(17), .ACC_W(20), .LEN_W(8)) dut20 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus20)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          len;
    int          prods[8];
    logic [15:0] pat;
    int          delay;
    bit          noise;
    longint      exp_res;
    bit          exp_ovf;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: running sum clamped to the w-bit signed range, sticky overflow flag.
  function automatic void model(input int prods[$], input int w, output longint r, output bit o);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -(longint'(1) <<< (w - 1));
    r = 0;
    o = 1'b0;
    foreach (prods[i]) begin
      r += prods[i];
      if (r > mx) begin r = mx; o = 1'b1; end
      else if (r < mn) begin r = mn; o = 1'b1; end
    end
  endfunction

  task automatic run32(input string name, input int len, input int prods[$], input logic [15:0] pat,
                       input int delay, input bit noise, input longint exp_res, input bit exp_ovf);
    int idx = 0;
    int cyc = 0;
    bus.start = 1'b1;
    bus.len   = 8'(len);
    tick();
    bus.start = 1'b0;
    while (idx < len) begin
      if (cyc > 2000) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: accepted %0d, expected %0d beats", name, idx, len);
        break;
      end
      check($sformatf("%s prod_ready", name), longint'(bus.prod_ready), 1);
      bus.prod_valid = pat[cyc % 16];
      bus.prod       = 17'(prods[idx]);
      if (noise) begin
        bus.start = 1'($urandom);
        bus.len   = 8'($urandom);
      end
      tick();
      if (bus.prod_valid) idx++;
      cyc++;
    end
    bus.prod_valid = 1'b0;
    bus.start      = 1'b0;
    check($sformatf("%s res_valid", name), longint'(bus.res_valid), 1);
    check($sformatf("%s prod_ready_done", name), longint'(bus.prod_ready), 0);
    check($sformatf("%s busy", name), longint'(bus.busy), 1);
    check($sformatf("%s res", name), longint'($signed(bus.res)), exp_res);
    check($sformatf("%s ovf", name), longint'(bus.res_ovf), longint'(exp_ovf));
    for (int d = 0; d < delay; d++) begin
      bus.start = noise ? 1'($urandom) : 1'b0;
      bus.len   = 8'($urandom);
      tick();
      check($sformatf("%s hold_valid", name), longint'(bus.res_valid), 1);
      check($sformatf("%s hold_res", name), longint'($signed(bus.res)), exp_res);
    end
    bus.res_ready = 1'b1;
    bus.start     = noise;
    tick();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    check($sformatf("%s idle_valid", name), longint'(bus.res_valid), 0);
    check($sformatf("%s idle_busy", name), longint'(bus.busy), 0);
    check($sformatf("%s idle_res", name), longint'($signed(bus.res)), 0);
  endtask

  task automatic run20(input string name, input int prods[$], input longint exp_res, input bit exp_ovf);
    bus20.start = 1'b1;
    bus20.len   = 8'(prods.size());
    tick();
    bus20.start      = 1'b0;
    bus20.prod_valid = 1'b1;
    foreach (prods[i]) begin
      bus20.prod = 17'(prods[i]);
      tick();
    end
    bus20.prod_valid = 1'b0;
    check($sformatf("%s res_valid", name), longint'(bus20.res_valid), 1);
    check($sformatf("%s res", name), longint'($signed(bus20.res)), exp_res);
    check($sformatf("%s ovf", name), longint'(bus20.res_ovf), longint'(exp_ovf));
    bus20.res_ready = 1'b1;
    tick();
    bus20.res_ready = 1'b0;
    check($sformatf("%s idle_busy", name), longint'(bus20.busy), 0);
  endtask

  vec_t tbl[5];

  initial begin
    int q[$];
    longint r;
    bit o;

    tbl[0] = '{len: 4, prods: '{3, -5, 100, -1, 0, 0, 0, 0}, pat: 16'hFFFF, delay: 0,
               noise: 1'b0, exp_res: 97, exp_ovf: 1'b0};
    tbl[1] = '{len: 3, prods: '{10, -20, 7, 0, 0, 0, 0, 0}, pat: 16'hFFE9, delay: 5,
               noise: 1'b0, exp_res: -3, exp_ovf: 1'b0};
    tbl[2] = '{len: 0, prods: '{0, 0, 0, 0, 0, 0, 0, 0}, pat: 16'hFFFF, delay: 2,
               noise: 1'b1, exp_res: 0, exp_ovf: 1'b0};
    tbl[3] = '{len: 2, prods: '{-65536, 65535, 0, 0, 0, 0, 0, 0}, pat: 16'h5555, delay: 1,
               noise: 1'b1, exp_res: -1, exp_ovf: 1'b0};
    tbl[4] = '{len: 8, prods: '{-65536, -65536, -65536, -65536, -65536, -65536, -65536, -65536},
               pat: 16'hFFFF, delay: 0, noise: 1'b1, exp_res: -524288, exp_ovf: 1'b0};

    bus.start = 1'b1;  bus.len = 8'd3;  bus.prod_valid = 1'b0;  bus.prod = '0;  bus.res_ready = 1'b0;
    bus20.start = 1'b0; bus20.len = '0; bus20.prod_valid = 1'b0; bus20.prod = '0; bus20.res_ready = 1'b0;

    // Reset held with start high: nothing may leave IDLE.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst prod_ready", longint'(bus.prod_ready), 0);
    check("rst res_valid", longint'(bus.res_valid), 0);
    check("rst busy", longint'(bus.busy), 0);
    check("rst res", longint'($signed(bus.res)), 0);
    check("rst ovf", longint'(bus.res_ovf), 0);
    bus.len = 8'd1;
    rst_n   = 1'b1;
    tick();
    bus.start = 1'b0;
    check("post_rst busy", longint'(bus.busy), 1);
    check("post_rst prod_ready", longint'(bus.prod_ready), 1);
    bus.prod_valid = 1'b1;
    bus.prod       = 17'd5;
    tick();
    bus.prod_valid = 1'b0;
    check("post_rst res_valid", longint'(bus.res_valid), 1);
    check("post_rst res", longint'($signed(bus.res)), 5);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("post_rst idle", longint'(bus.busy), 0);

    for (int k = 0; k < 5; k++) begin
      q = {};
      for (int i = 0; i < tbl[k].len; i++) q.push_back(tbl[k].prods[i]);
      run32($sformatf("vec%0d", k), tbl[k].len, q, tbl[k].pat, tbl[k].delay, tbl[k].noise,
            tbl[k].exp_res, tbl[k].exp_ovf);
    end

    // Saturation on the narrow accumulator, both directions.
    q = {};
    for (int i = 0; i < 255; i++) q.push_back(65535);
    run20("sat_pos", q, 524287, 1'b1);
    q = {};
    for (int i = 0; i < 255; i++) q.push_back(-65536);
    run20("sat_neg", q, -524288, 1'b1);
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(65535);
    for (int i = 0; i < 3; i++) q.push_back(-65536);
    run20("sat_recover", q, 327679, 1'b1);
    for (int n = 0; n < 3; n++) begin
      q = {};
      for (int i = 0; i < 60; i++) q.push_back(int'($urandom_range(131071)) - 65536);
      model(q, 20, r, o);
      run20($sformatf("rnd20_%0d", n), q, r, o);
    end

    // Reset mid-run abandons everything accumulated so far.
    bus.start = 1'b1;
    bus.len   = 8'd4;
    tick();
    bus.start      = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod       = 17'd1000;
    tick();
    bus.prod = 17'd2000;
    tick();
    bus.prod_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("abort prod_ready", longint'(bus.prod_ready), 0);
    check("abort busy", longint'(bus.busy), 0);
    check("abort res_valid", longint'(bus.res_valid), 0);
    rst_n = 1'b1;
    q = {-7};
    run32("after_abort", 1, q, 16'hFFFF, 0, 1'b0, -7, 1'b0);

    for (int n = 0; n < 8; n++) begin
      int len;
      logic [15:0] pat;
      len = int'($urandom_range(40, 1));
      pat = 16'($urandom) | 16'h0001;
      q = {};
      for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(131071)) - 65536);
      model(q, 32, r, o);
      run32($sformatf("rnd32_%0d", n), len, q, pat, int'($urandom_range(4)), 1'($urandom), r, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
